fetch_ir_unit: RTL

- Upstream neighbour of the multicycle controller.
- Owns the PC, the instruction register (IR) and the memory data register (DR).
- Runs a request/ready handshake to instruction memory, so fetches may take variable latency. Decodes the latched IR into the op/funct/register fields that the controller and register file consume.
- Asserts stall while a fetch is outstanding; the controller freezes its state on stall.

---
 rtl/fetch_ir_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ir_unit.sv
// ============================================================================
// Module   : fetch_ir_unit
// Purpose  : PC / IR / DR owner with request-ready instruction fetch and decode.
//            Optional FETCH_TIMEOUT_EN macro adds a per-fetch timeout (NOP + sticky fetch_err).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ir_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irwrite,
  input  logic             pcen,
  input  logic [1:0]       pcsrc,
  input  logic             iord,
  input  logic [WIDTH-1:0] aluresult,
  input  logic [WIDTH-1:0] aluout,
  input  logic [WIDTH-1:0] memrdata,
  input  logic             memready,
  output logic             memreq,
  output logic [WIDTH-1:0] memaddr,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] dr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic             stall,
  output logic             ir_valid,
  output logic             fetch_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic             ir_valid_q, ir_valid_d;
  logic             w_load_ir;
  logic             w_timeout;
  logic             w_stall;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (irwrite && !memready) state_d = S_WAIT;
      S_WAIT:  if (memready || w_timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by reset so outputs read as idle while reset is held.
  always_comb begin
    w_stall   = reset && ((state_q == S_WAIT) || irwrite);
    w_load_ir = memready && ((state_q == S_WAIT) || irwrite);
    memreq    = w_stall;
    stall     = w_stall;
  end

  // ---------------------------------------------------------------- timeout
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          fetch_err_q, fetch_err_d;

  assign w_timeout = (state_q == S_WAIT) && !memready && (wcnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    wcnt_d      = wcnt_q;
    fetch_err_d = fetch_err_q | w_timeout;
    if (state_q == S_IDLE) begin
      wcnt_d = '0;
    end else if (!memready) begin
      wcnt_d = wcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic unused_timeout;

  assign w_timeout      = 1'b0;
  assign fetch_err      = 1'b0;
  assign unused_timeout = (TIMEOUT < 2);
`endif

  // ---------------------------------------------------------------- datapath
  always_comb begin
    instr_d    = instr_q;
    ir_valid_d = w_load_ir | w_timeout;
    if (w_load_ir) begin
      instr_d = memrdata[31:0];
    end else if (w_timeout) begin
      instr_d = 32'h0;
    end
  end

  always_comb begin
    dr_d = dr_q;
    if (memready && (state_q == S_IDLE) && !irwrite) begin
      dr_d = memrdata;
    end
  end

  // A PC write during a stall is dropped; the controller re-issues it.
  always_comb begin
    pc_d = pc_q;
    if (pcen && !w_stall) begin
      case (pcsrc)
        2'b00:   pc_d = aluresult;
        2'b01:   pc_d = aluout;
        2'b10:   pc_d = {pc_q[WIDTH-1:28], instr_q[25:0], 2'b00};
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      dr_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      dr_q       <= dr_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign memaddr  = iord ? aluout : pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign dr       = dr_q;
  assign ir_valid = ir_valid_q;
  assign op       = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign funct    = instr_q[5:0];
  assign imm      = instr_q[15:0];

endmodule

`default_nettype wire
